collision_scorer: RTL and testbench

- Consumes the per-pixel sprite flags (player ship, player bullet, enemy) produced by the display/sprite stage during active scan.
- Detects bullet–enemy and ship–enemy overlap and evaluates once per frame on the animate strobe.
- Produces hit/crash pulses, a 4-digit BCD score, a remaining-lives count and game-over status.
- These outputs feed the sprite movers (bullet/enemy respawn) and the score display.

---
 rtl/collision_scorer_if.sv | 31 +++
 rtl/collision_scorer.sv | 137 +++++++++++++
 tb/tb_collision_scorer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/collision_scorer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// collision_scorer_if : sprite-flag inputs and score/status outputs
// Rev 1.0
// ---------------------------------------------------------------------------
interface collision_scorer_if;
    logic        i_pix_stb;
    logic        i_animate;
    logic        i_paused;
    logic        i_player;
    logic        i_bullet;
    logic        i_enemy;
    logic        i_start;
    logic        o_hit;
    logic        o_crash;
    logic [15:0] o_score;
    logic [2:0]  o_lives;
    logic        o_invuln;
    logic        o_game_over;

    modport master (
        output i_pix_stb, i_animate, i_paused, i_player, i_bullet, i_enemy, i_start,
        input  o_hit, o_crash, o_score, o_lives, o_invuln, o_game_over
    );

    modport slave (
        input  i_pix_stb, i_animate, i_paused, i_player, i_bullet, i_enemy, i_start,
        output o_hit, o_crash, o_score, o_lives, o_invuln, o_game_over
    );
endinterface
`default_nettype wire

// File: rtl/collision_scorer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// collision_scorer : per-frame bullet/ship vs enemy overlap scoring and lives
// Rev 1.0
// ---------------------------------------------------------------------------
module collision_scorer #(
    parameter int LIVES        = 3,
    parameter int CRASH_FRAMES = 60
) (
    input  wire                 i_clk,
    input  wire                 i_rst_n,
    collision_scorer_if.slave   bus
);
    localparam logic [1:0] c_PLAY      = 2'd0;
    localparam logic [1:0] c_CRASH     = 2'd1;
    localparam logic [1:0] c_GAME_OVER = 2'd2;

    localparam logic [2:0] c_LIVES  = 3'(LIVES);
    localparam logic [7:0] c_FRAMES = 8'(CRASH_FRAMES);

    logic [1:0]  state_q, state_d;
    logic        hit_flag_q, hit_flag_d;
    logic        crash_flag_q, crash_flag_d;
    logic [15:0] score_q, score_d;
    logic [2:0]  lives_q, lives_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        hit_q, hit_d;
    logic        crash_q, crash_d;
    logic [2:0]  w_lives_dec;
    logic [7:0]  w_cnt_dec;

    // Saturating 4-digit BCD increment with per-digit carry.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (r[4*i +: 4] == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= c_PLAY;
            hit_flag_q   <= 1'b0;
            crash_flag_q <= 1'b0;
            score_q      <= 16'h0000;
            lives_q      <= c_LIVES;
            cnt_q        <= 8'd0;
            hit_q        <= 1'b0;
            crash_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            hit_flag_q   <= hit_flag_d;
            crash_flag_q <= crash_flag_d;
            score_q      <= score_d;
            lives_q      <= lives_d;
            cnt_q        <= cnt_d;
            hit_q        <= hit_d;
            crash_q      <= crash_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        lives_d     = lives_q;
        cnt_d       = cnt_q;
        hit_d       = 1'b0;
        crash_d     = 1'b0;
        w_lives_dec = lives_q - 3'd1;
        w_cnt_dec   = cnt_q - 8'd1;

        // Samples landing on the animate cycle belong to no frame and are dropped.
        if (bus.i_animate) begin
            hit_flag_d   = 1'b0;
            crash_flag_d = 1'b0;
        end else begin
            hit_flag_d   = hit_flag_q   | (bus.i_pix_stb & bus.i_bullet & bus.i_enemy);
            crash_flag_d = crash_flag_q | (bus.i_pix_stb & bus.i_player & bus.i_enemy);
        end

        if (state_q == c_GAME_OVER) begin
            if (bus.i_start) begin
                state_d      = c_PLAY;
                score_d      = 16'h0000;
                lives_d      = c_LIVES;
                cnt_d        = 8'd0;
                hit_flag_d   = 1'b0;
                crash_flag_d = 1'b0;
            end
        end else if (bus.i_animate && !bus.i_paused) begin
            if (state_q == c_PLAY && crash_flag_q) begin
                crash_d = 1'b1;
                lives_d = w_lives_dec;
                if (w_lives_dec == 3'd0) begin
                    state_d = c_GAME_OVER;
                end else begin
                    state_d = c_CRASH;
                    cnt_d   = c_FRAMES;
                end
            end else begin
                if (hit_flag_q) begin
                    hit_d   = 1'b1;
                    score_d = bcd_inc(score_q);
                end
                if (state_q == c_CRASH) begin
                    cnt_d = w_cnt_dec;
                    if (w_cnt_dec == 8'd0) begin
                        state_d = c_PLAY;
                    end
                end
            end
        end
    end

    always_comb begin
        bus.o_hit       = hit_q;
        bus.o_crash     = crash_q;
        bus.o_score     = score_q;
        bus.o_lives     = lives_q;
        bus.o_invuln    = (state_q == c_CRASH);
        bus.o_game_over = (state_q == c_GAME_OVER);
    end
endmodule
`default_nettype wire

// File: tb/tb_collision_scorer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_collision_scorer : directed self-checking bench for collision_scorer
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_collision_scorer;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    logic obs_hit, obs_crash, nxt_hit, nxt_crash;

    collision_scorer_if bus ();

    collision_scorer #(
        .LIVES        (3),
        .CRASH_FRAMES (3)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.i_pix_stb = 1'b0;
        bus.i_animate = 1'b0;
        bus.i_paused  = 1'b0;
        bus.i_player  = 1'b0;
        bus.i_bullet  = 1'b0;
        bus.i_enemy   = 1'b0;
        bus.i_start   = 1'b0;
    endtask

    // Overlap on two strobed pixels, then an animate cycle; capture pulse and the cycle after.
    task automatic frame(input logic b, input logic p, input logic ps);
        @(negedge clk);
        bus.i_pix_stb = 1'b1; bus.i_bullet = b; bus.i_player = p; bus.i_enemy = b | p;
        @(negedge clk);
        bus.i_pix_stb = 1'b0;
        @(negedge clk);
        bus.i_pix_stb = 1'b1;
        @(negedge clk);
        idle_inputs();
        bus.i_animate = 1'b1; bus.i_paused = ps;
        @(negedge clk);
        idle_inputs();
        obs_hit = bus.o_hit; obs_crash = bus.o_crash;
        @(negedge clk);
        nxt_hit = bus.o_hit; nxt_crash = bus.o_crash;
    endtask

    task automatic quick_hit();
        @(negedge clk);
        bus.i_pix_stb = 1'b1; bus.i_bullet = 1'b1; bus.i_enemy = 1'b1;
        @(negedge clk);
        idle_inputs();
        bus.i_animate = 1'b1;
        @(negedge clk);
        bus.i_animate = 1'b0;
    endtask

    task automatic start_pulse();
        @(negedge clk);
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_score", bus.o_score, 16'h0000);
        check("rst_lives", 16'(bus.o_lives), 16'd3);
        check("rst_hit", 16'(bus.o_hit), 16'd0);
        check("rst_crash", 16'(bus.o_crash), 16'd0);
        check("rst_invuln", 16'(bus.o_invuln), 16'd0);
        check("rst_game_over", 16'(bus.o_game_over), 16'd0);
        rst_n = 1'b1;

        frame(1'b1, 1'b0, 1'b0);
        check("first_hit_pulse", 16'(obs_hit), 16'd1);
        check("first_hit_one_cycle", 16'(nxt_hit), 16'd0);
        check("first_hit_score", bus.o_score, 16'h0001);
        check("first_hit_lives", 16'(bus.o_lives), 16'd3);

        repeat (98) quick_hit();
        @(negedge clk);
        check("score_0099", bus.o_score, 16'h0099);
        frame(1'b1, 1'b0, 1'b0);
        check("carry_hit_pulse", 16'(obs_hit), 16'd1);
        check("score_0100", bus.o_score, 16'h0100);

        repeat (9899) quick_hit();
        @(negedge clk);
        check("score_9999", bus.o_score, 16'h9999);
        frame(1'b1, 1'b0, 1'b0);
        check("sat_hit_pulse", 16'(obs_hit), 16'd1);
        check("sat_score", bus.o_score, 16'h9999);

        // Crash beats hit in the same frame.
        frame(1'b1, 1'b1, 1'b0);
        check("prio_crash", 16'(obs_crash), 16'd1);
        check("prio_crash_one_cycle", 16'(nxt_crash), 16'd0);
        check("prio_hit", 16'(obs_hit), 16'd0);
        check("prio_lives", 16'(bus.o_lives), 16'd2);
        check("prio_invuln", 16'(bus.o_invuln), 16'd1);
        check("prio_score", bus.o_score, 16'h9999);

        frame(1'b0, 1'b1, 1'b0);
        check("invuln_no_crash", 16'(obs_crash), 16'd0);
        check("invuln_lives", 16'(bus.o_lives), 16'd2);
        frame(1'b0, 1'b0, 1'b1);
        check("invuln_paused", 16'(bus.o_invuln), 16'd1);
        frame(1'b0, 1'b0, 1'b0);
        check("invuln_second", 16'(bus.o_invuln), 16'd1);
        frame(1'b0, 1'b0, 1'b0);
        check("invuln_third", 16'(bus.o_invuln), 16'd0);

        frame(1'b0, 1'b1, 1'b0);
        check("crash2_pulse", 16'(obs_crash), 16'd1);
        check("crash2_lives", 16'(bus.o_lives), 16'd1);
        repeat (3) frame(1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b1, 1'b0);
        check("crash3_pulse", 16'(obs_crash), 16'd1);
        check("crash3_lives", 16'(bus.o_lives), 16'd0);
        check("crash3_game_over", 16'(bus.o_game_over), 16'd1);
        check("crash3_invuln", 16'(bus.o_invuln), 16'd0);

        frame(1'b1, 1'b1, 1'b0);
        check("go_no_hit", 16'(obs_hit), 16'd0);
        check("go_no_crash", 16'(obs_crash), 16'd0);
        check("go_score", bus.o_score, 16'h9999);

        start_pulse();
        check("restart_score", bus.o_score, 16'h0000);
        check("restart_lives", 16'(bus.o_lives), 16'd3);
        check("restart_game_over", 16'(bus.o_game_over), 16'd0);

        // Overlap only while the pixel strobe is low.
        @(negedge clk);
        bus.i_bullet = 1'b1; bus.i_enemy = 1'b1;
        repeat (3) @(negedge clk);
        idle_inputs();
        bus.i_animate = 1'b1;
        @(negedge clk);
        bus.i_animate = 1'b0;
        check("unstrobed_hit", 16'(bus.o_hit), 16'd0);

        // Strobed overlap only on the animate cycle itself.
        bus.i_pix_stb = 1'b1; bus.i_bullet = 1'b1; bus.i_enemy = 1'b1; bus.i_animate = 1'b1;
        @(negedge clk);
        idle_inputs();
        check("animate_sample_hit", 16'(bus.o_hit), 16'd0);
        frame(1'b0, 1'b0, 1'b0);
        check("animate_sample_next", 16'(obs_hit), 16'd0);

        frame(1'b1, 1'b0, 1'b1);
        check("paused_hit", 16'(obs_hit), 16'd0);
        frame(1'b0, 1'b0, 1'b0);
        check("paused_flag_cleared", 16'(obs_hit), 16'd0);
        check("paused_score", bus.o_score, 16'h0000);

        frame(1'b1, 1'b0, 1'b0);
        check("post_restart_hit", 16'(obs_hit), 16'd1);
        check("post_restart_score", bus.o_score, 16'h0001);

        start_pulse();
        check("start_in_play_score", bus.o_score, 16'h0001);
        check("start_in_play_lives", 16'(bus.o_lives), 16'd3);

        frame(1'b0, 1'b1, 1'b0);
        check("pre_reset_invuln", 16'(bus.o_invuln), 16'd1);
        check("pre_reset_lives", 16'(bus.o_lives), 16'd2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_invuln", 16'(bus.o_invuln), 16'd0);
        check("async_rst_lives", 16'(bus.o_lives), 16'd3);
        check("async_rst_score", bus.o_score, 16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Back in PLAY after reset, so a crash is taken; then a hit scores during CRASH.
        frame(1'b0, 1'b1, 1'b0);
        check("post_reset_crash", 16'(obs_crash), 16'd1);
        check("post_reset_lives", 16'(bus.o_lives), 16'd2);
        frame(1'b1, 1'b0, 1'b0);
        check("crash_state_hit", 16'(obs_hit), 16'd1);
        check("crash_state_score", bus.o_score, 16'h0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
